// File: rtl/sum_decoder.sv
// sum_decoder: recovers the per-cycle samples from a running-sum stream
// by differencing consecutive accumulator values modulo 2^SUM_W.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   sum_valid  sum_in/wrap_in carry a new accumulator value this cycle
//   sum_in     running sum from the accumulator (SUM_W bits)
//   wrap_in    accumulator overflow flag for this sample
//   resync     accumulator was cleared; reference sum returns to 0
//   data_out   recovered sample (DATA_W bits)
//   data_valid one-cycle pulse, data_out is valid
//   range_err  sticky error: difference out of range or wrap mismatch
//   wrap_cnt   accumulator wraps seen, saturating at 255
//
// Build option: define SUM_DECODER_CHECK_EN to compile in the range and
// wrap-consistency checks and the ERR state. Without it range_err is 0
// and every accepted sample is output truncated to DATA_W bits.
module sum_decoder #(
    parameter int SUM_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sum_valid,
    input  logic [SUM_W-1:0]  sum_in,
    input  logic              wrap_in,
    input  logic              resync,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              range_err,
    output logic [7:0]        wrap_cnt
);

`ifdef SUM_DECODER_CHECK_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
`endif

    state_t           state;
    logic [SUM_W-1:0] prev;
    logic [SUM_W-1:0] base;
    logic [SUM_W-1:0] d;
    logic             accept;
    logic             wrap_inc;

    // prev is already 0 in IDLE; forcing the base keeps the first
    // difference independent of any stale register contents.
    assign base     = (state == IDLE) ? '0 : prev;
    assign d        = sum_in - base;
    assign wrap_inc = wrap_in && (wrap_cnt != 8'hFF);

`ifdef SUM_DECODER_CHECK_EN
    logic borrow;
    logic check_fail;
    logic err_q;

    assign accept     = sum_valid && (state != ERR);
    assign borrow     = (sum_in < base);
    // Reject a difference that does not fit in DATA_W bits, or an
    // overflow flag that disagrees with the observed borrow.
    assign check_fail = (d[SUM_W-1:DATA_W] != '0) ||
                        (wrap_in != borrow);
    assign range_err  = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            prev       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            wrap_cnt   <= '0;
            err_q      <= 1'b0;
        end else if (resync) begin
            state      <= IDLE;
            prev       <= '0;
            data_valid <= 1'b0;
            wrap_cnt   <= '0;
            err_q      <= 1'b0;
        end else if (accept && check_fail) begin
            state      <= ERR;
            data_valid <= 1'b0;
            err_q      <= 1'b1;
        end else if (accept) begin
            state      <= RUN;
            prev       <= sum_in;
            data_out   <= d[DATA_W-1:0];
            data_valid <= 1'b1;
            if (wrap_inc) begin
                wrap_cnt <= wrap_cnt + 8'd1;
            end
        end else begin
            data_valid <= 1'b0;
        end
    end
`else
    // Upper difference bits only matter to the checks.
    logic unused_hi;

    assign accept    = sum_valid;
    assign unused_hi = ^d[SUM_W-1:DATA_W];
    assign range_err = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            prev       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            wrap_cnt   <= '0;
        end else if (resync) begin
            state      <= IDLE;
            prev       <= '0;
            data_valid <= 1'b0;
            wrap_cnt   <= '0;
        end else if (accept) begin
            state      <= RUN;
            prev       <= sum_in;
            data_out   <= d[DATA_W-1:0];
            data_valid <= 1'b1;
            if (wrap_inc) begin
                wrap_cnt <= wrap_cnt + 8'd1;
            end
        end else begin
            data_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sum_decoder.sv
// tb_sum_decoder: directed and random stimulus for sum_decoder,
// compared against a behavioural difference model.
module tb_sum_decoder;

`ifdef SUM_DECODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        sum_valid = 1'b0;
    logic [15:0] sum_in    = '0;
    logic        wrap_in   = 1'b0;
    logic        resync    = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        range_err;
    logic [7:0]  wrap_cnt;

    int total = 0;
    int bad   = 0;

    int m_prev = 0;
    int m_dout = 0;
    int m_wcnt = 0;
    bit m_dv   = 1'b0;
    bit m_err  = 1'b0;
    bit m_lock = 1'b0;

    sum_decoder #(.SUM_W(16), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sum_valid  (sum_valid),
        .sum_in     (sum_in),
        .wrap_in    (wrap_in),
        .resync     (resync),
        .data_out   (data_out),
        .data_valid (data_valid),
        .range_err  (range_err),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: sample = difference of consecutive sums mod 2^16.
    task automatic model_edge();
        int d;
        bit fail;
        if (!reset) begin
            m_prev = 0; m_dout = 0; m_wcnt = 0;
            m_dv = 0; m_err = 0; m_lock = 0;
        end else if (resync) begin
            m_prev = 0; m_wcnt = 0;
            m_dv = 0; m_err = 0; m_lock = 0;
        end else if (sum_valid && !m_lock) begin
            d = (int'(sum_in) - m_prev + 65536) % 65536;
            fail = CHK && ((d > 255) ||
                   (wrap_in != (int'(sum_in) < m_prev)));
            if (fail) begin
                m_err = 1; m_dv = 0; m_lock = 1;
            end else begin
                m_dout = d % 256;
                m_dv = 1;
                m_prev = int'(sum_in);
                if (wrap_in && m_wcnt < 255) m_wcnt++;
            end
        end else begin
            m_dv = 0;
        end
    endtask

    task automatic step(bit v, int s, bit w, bit rs, string tag);
        sum_valid = v;
        sum_in    = s[15:0];
        wrap_in   = w;
        resync    = rs;
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".dout"}, int'(data_out), m_dout);
        check({tag, ".dv"},   int'(data_valid), int'(m_dv));
        check({tag, ".err"},  int'(range_err), int'(m_err));
        check({tag, ".wcnt"}, int'(wrap_cnt), m_wcnt);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(0, 0, 0, 0, "rst");
        reset = 1'b1;
    endtask

    // Advance the sum in legal steps (<=200) until it equals target.
    task automatic walk_to(int target);
        int rem, inc, s;
        for (int n = 0; n < 400; n++) begin
            rem = (target - m_prev + 65536) % 65536;
            if (rem == 0 || m_lock) break;
            inc = (rem > 200) ? 200 : rem;
            s = (m_prev + inc) % 65536;
            step(1, s, s < m_prev, 0, "walk");
        end
    endtask

    initial begin
        int sums[5];
        int w0, s, r, dlt;
        sums = '{0, 1, 3, 6, 10};

        // reset state
        do_reset();
        check("rst.lit.dout", int'(data_out), 0);
        check("rst.lit.dv",   int'(data_valid), 0);
        check("rst.lit.err",  int'(range_err), 0);
        check("rst.lit.wcnt", int'(wrap_cnt), 0);

        // counter stream
        for (int i = 0; i < 5; i++) begin
            step(1, sums[i], 0, 0, "cnt");
            check("cnt.lit.dout", int'(data_out), i);
            check("cnt.lit.dv", int'(data_valid), 1);
        end
        step(0, 0, 0, 0, "cnt.gap");
        check("cnt.lit.err", int'(range_err), 0);

        // wrap across 2^16
        do_reset();
        walk_to(16'hFFF0);
        w0 = m_wcnt;
        step(1, 16'h0010, 1, 0, "wrap");
        check("wrap.lit.dout", int'(data_out), 8'h20);
        check("wrap.lit.wcnt", int'(wrap_cnt), w0 + 1);
        check("wrap.lit.err", int'(range_err), 0);

        // difference too large
        do_reset();
        step(1, 16'h0100, 0, 0, "rng");
`ifdef SUM_DECODER_CHECK_EN
        check("rng.lit.err", int'(range_err), 1);
        check("rng.lit.dv", int'(data_valid), 0);
        step(1, 16'h0101, 0, 0, "rng.hold");
        check("rng.lit.hold.dv", int'(data_valid), 0);
`else
        check("rng.lit.dout", int'(data_out), 0);
        check("rng.lit.dv", int'(data_valid), 1);
        check("rng.lit.err", int'(range_err), 0);
`endif
        step(0, 0, 0, 1, "rng.rs");
        step(1, 5, 0, 0, "rng.after");
        check("rng.lit.after", int'(data_out), 5);

        // wrap flag without a borrow
        do_reset();
        step(1, 16'h0010, 0, 0, "wmis.pre");
        step(1, 16'h0012, 1, 0, "wmis");
`ifdef SUM_DECODER_CHECK_EN
        check("wmis.lit.err", int'(range_err), 1);
`else
        check("wmis.lit.dout", int'(data_out), 2);
`endif

        // reset mid-stream, then gaps
        do_reset();
        step(1, 5, 0, 0, "mid");
        step(1, 9, 0, 0, "mid");
        reset = 1'b0;
        step(1, 20, 0, 0, "mid.rst");
        reset = 1'b1;
        check("mid.lit.dout", int'(data_out), 0);
        check("mid.lit.dv", int'(data_valid), 0);
        step(1, 4, 0, 0, "mid.first");
        check("mid.lit.first", int'(data_out), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, $urandom_range(0, 65535), 1, 0, "gap");
            check("gap.lit.dout", int'(data_out), 4);
        end

        // wrap counter saturation
        do_reset();
`ifdef SUM_DECODER_CHECK_EN
        for (int lap = 0; lap < 2; lap++) begin
            walk_to(16'hFF00);
            walk_to(16'h0010);
        end
        check("sat.lit.laps", int'(wrap_cnt), 2);
`else
        for (int i = 0; i < 300; i++) begin
            step(1, $urandom_range(0, 65535), 1, 0, "sat");
        end
        check("sat.lit.wcnt", int'(wrap_cnt), 255);
`endif

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                reset = 1'b0;
                step(1, $urandom_range(0, 65535), 0, 0, "rnd.rst");
                reset = 1'b1;
            end else if (r < 4) begin
                step($urandom_range(0, 1), $urandom_range(0, 65535),
                     1'($urandom_range(0, 1)), 1, "rnd.rs");
            end else if (r < 14) begin
                step(0, $urandom_range(0, 65535),
                     1'($urandom_range(0, 1)), 0, "rnd.gap");
            end else if (r < 17) begin
                step(1, $urandom_range(0, 65535),
                     1'($urandom_range(0, 1)), 0, "rnd.bad");
            end else begin
                dlt = $urandom_range(0, 255);
                s = (m_prev + dlt) % 65536;
                step(1, s, s < m_prev, 0, "rnd.ok");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_decoder.md
# sum_decoder

- Reconstructs the per-cycle 8-bit data stream from the 16-bit running total produced by the team's `sum` accumulator.
- Each valid sample: `data_out = sum_in - previous sum_in`, modulo 2^SUM_W.
- Sits at the far end of a sum link and recovers the counter values that were accumulated.
- Checks wrap consistency and flags differences that cannot fit in DATA_W bits.

## Interface

Parameters:
- `SUM_W`, 16, width of the running-sum input.
- `DATA_W`, 8, width of the recovered sample; must be less than `SUM_W`.

Ports:
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, synchronous, active-low.
- `sum_valid` input, 1 bit: `sum_in` and `wrap_in` carry a new accumulator value this cycle.
- `sum_in` input, `SUM_W` bits: running sum from the accumulator.
- `wrap_in` input, 1 bit: the accumulator's overflow flag for this sample (sum wrapped past 2^SUM_W).
- `resync` input, 1 bit: accumulator was cleared; the reference sum returns to 0.
- `data_out` output, `DATA_W` bits: recovered sample.
- `data_valid` output, 1 bit: one-cycle pulse, `data_out` is valid.
- `range_err` output, 1 bit: sticky error, difference out of range or wrap mismatch.
- `wrap_cnt` output, 8 bits: number of accumulator wraps seen, saturating at 255.

## Operation

- Internal register `prev` (`SUM_W` bits) holds the last accepted sum. Its value is 0 after reset and after resync, which matches an accumulator that starts at 0.
- FSM states:
  - IDLE: no sample has been accepted since reset or resync.
  - RUN: at least one sample has been accepted.
  - ERR: a check failed; stays here until resync or reset.
- Transitions:
  - IDLE goes to RUN on the first accepted sample.
  - RUN goes to ERR on a check failure.
  - Any state goes to IDLE on `resync`.
- Per accepted sample (`sum_valid`=1 while in IDLE or RUN):
  - `d = (sum_in - prev) mod 2^SUM_W`.
  - `borrow = (sum_in < prev)`.
  - `data_out <= d[DATA_W-1:0]`, `data_valid <= 1`, `prev <= sum_in`.
  - If `wrap_in`=1, `wrap_cnt` increments unless it is already 255.
- Modular subtraction makes the result correct across an accumulator wrap. No special case is needed.
- In ERR, `sum_valid` is ignored: `prev`, `data_out` and `wrap_cnt` hold, and `data_valid` stays 0.
- `sum_valid`=0: all registers hold and `data_valid`=0. Gaps between samples are allowed.
- Simultaneous events:
  - `resync` together with `sum_valid`: resync wins. The sample is discarded, `prev` is set to 0, the state goes to IDLE, and `range_err` and `wrap_cnt` clear.
  - Reset overrides everything.

## Timing

- Reset values:
  - `data_out` = 0
  - `data_valid` = 0
  - `range_err` = 0
  - `wrap_cnt` = 0
  - `prev` = 0
  - state = IDLE
- Latency is 1 cycle: a sample accepted at clock edge N appears on `data_out` with `data_valid`=1 during cycle N+1.
- Throughput is one sample per cycle with no backpressure.
- `range_err` rises in the same cycle that `data_valid` would have risen.
- Reset asserted mid-stream takes effect at the next clock edge. Any in-flight `data_valid` is dropped.

## Configuration

- Macro: `SUM_DECODER_CHECK_EN`.
- When defined, the checks are compiled in. A check fails if either:
  - `d[SUM_W-1:DATA_W]` is not zero, or
  - `wrap_in` does not equal `borrow`.
- On a failed check:
  - `range_err <= 1`; it is sticky.
  - `data_valid` stays 0.
  - `prev` does not update.
  - The state goes to ERR.
- When not defined:
  - No checks are made and the ERR state does not exist.
  - `range_err` is tied to 0.
  - Every accepted sample outputs `d[DATA_W-1:0]`, i.e. truncated.

## Test plan

- **Counter stream.** Reset, then feed sums 0, 1, 3, 6, 10 on consecutive cycles. Expect `data_out` = 0, 1, 2, 3, 4, each with a `data_valid` pulse one cycle later. Expect `range_err` = 0.
- **Wrap.** Set `prev` = 0xFFF0, then feed `sum_in` = 0x0010 with `wrap_in` = 1. Expect `data_out` = 0x20 and `wrap_cnt` incremented by 1. With the checks enabled, expect no error.
- **Range error (macro defined).** After reset, feed `sum_in` = 0x0100. Expect `range_err` = 1 and `data_valid` = 0. The following samples produce no output. Then assert `resync`, feed 0x0005, and expect `data_out` = 5.
- **Range error (macro undefined).** Use the same stimulus. Expect `data_out` = 0x00 with `data_valid` = 1 and `range_err` = 0.
- **Wrap mismatch (macro defined).** Set `prev` = 0x0010, then feed `sum_in` = 0x0012 with `wrap_in` = 1. Expect `range_err` = 1.
- **Reset mid-stream, gaps, saturation.**
  - Feed 5 and 9, then drop `reset` for one cycle. Expect all outputs at 0.
  - Then feed 4. Expect `data_out` = 4.
  - Apply idle cycles between samples; outputs must hold.
  - Apply 300 wraps. Expect `wrap_cnt` = 255.
